// File: rtl/wb_port_arbiter_rr.sv
// N-port Wishbone arbiter feeding the SDRAM controller's single 32-bit access interface.
// state   | meaning
// IDLE    | no grant held; arbitrate among requesting ports
// ACTIVE  | grant held; forward the granted port's cycle downstream
// RELEASE | one dead cycle between grants; any late ack_i is dropped
`timescale 1ns/1ps
module wb_port_arbiter_rr #(
  parameter int WB_PORTS  = 3,
  parameter int ARB_MODE  = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [WB_PORTS*32-1:0] wb_adr_i,
  input  logic [WB_PORTS-1:0]    wb_stb_i,
  input  logic [WB_PORTS-1:0]    wb_cyc_i,
  input  logic [WB_PORTS*3-1:0]  wb_cti_i,
  input  logic [WB_PORTS-1:0]    wb_we_i,
  input  logic [WB_PORTS*4-1:0]  wb_sel_i,
  input  logic [WB_PORTS*32-1:0] wb_dat_i,
  output logic [WB_PORTS*32-1:0] wb_dat_o,
  output logic [WB_PORTS-1:0]    wb_ack_o,
  output logic                   acc_o,
  output logic                   we_o,
  output logic [31:0]            adr_o,
  output logic [31:0]            dat_o,
  output logic [3:0]             sel_o,
  input  logic [31:0]            dat_i,
  input  logic                   ack_i,
  output logic [WB_PORTS-1:0]    grant_o
);
  localparam int IW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] BEAT_LIMIT = CW'(MAX_BEATS);
  localparam logic [IW-1:0] LAST_PORT  = IW'(WB_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state, w_next;
  logic [WB_PORTS-1:0] r_grant;
  logic [IW-1:0]       r_gidx, r_last, w_win;
  logic [CW-1:0]       r_beats;
  logic [WB_PORTS-1:0] w_req;
  logic [2:0]          w_cti;
  logic                w_cyc_g, w_stb_g, w_others, w_end, w_limit, w_release;

  assign w_req = wb_cyc_i & wb_stb_i;

  always_comb begin : arbitrate
    int idx;
    idx   = 0;
    w_win = '0;
    if (ARB_MODE == 0) begin
      for (int i = WB_PORTS - 1; i >= 0; i--)
        if (w_req[i]) w_win = IW'(i);
    end else begin
      // Scan downward so the nearest port after r_last is assigned last and wins.
      for (int k = WB_PORTS; k >= 1; k--) begin
        idx = (int'(r_last) + k) % WB_PORTS;
        if (w_req[IW'(idx)]) w_win = IW'(idx);
      end
    end
  end

  assign w_cti    = wb_cti_i[3*int'(r_gidx) +: 3];
  assign w_cyc_g  = wb_cyc_i[r_gidx];
  assign w_stb_g  = wb_stb_i[r_gidx];
  assign w_others = |(w_req & ~r_grant);
  assign w_end    = ack_i && (w_cti == 3'b000 || w_cti == 3'b111);
  // Saturating counter with >= so a late-arriving waiter still preempts a long burst.
  assign w_limit  = (MAX_BEATS != 0) && ack_i && w_others &&
                    ((r_beats + CW'(1)) >= BEAT_LIMIT);
  assign w_release = w_end || !w_cyc_g || w_limit;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin : next_state
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|w_req) w_next = S_ACTIVE;
      S_ACTIVE:  if (w_release) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= LAST_PORT;
      r_beats <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_grant <= WB_PORTS'(1) << w_win;
            r_gidx  <= w_win;
          end
        end
        S_ACTIVE: begin
          if (w_release) begin
            r_grant <= '0;
            r_last  <= r_gidx;
            r_beats <= '0;
          end else if (ack_i && r_beats != BEAT_LIMIT) begin
            r_beats <= r_beats + CW'(1);
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign acc_o    = (r_state == S_ACTIVE) && w_cyc_g && w_stb_g;
  assign wb_ack_o = (r_state == S_ACTIVE) ? (r_grant & {WB_PORTS{ack_i}}) : '0;
  assign adr_o    = wb_adr_i[32*int'(r_gidx) +: 32];
  assign dat_o    = wb_dat_i[32*int'(r_gidx) +: 32];
  assign sel_o    = wb_sel_i[4*int'(r_gidx) +: 4];
  assign we_o     = wb_we_i[r_gidx];
  assign wb_dat_o = {WB_PORTS{dat_i}};
  assign grant_o  = r_grant;

endmodule

// File: tb/tb_wb_port_arbiter_rr.sv
// Directed bench for wb_port_arbiter_rr: round-robin, fixed-priority and MAX_BEATS=4 instances.
`timescale 1ns/1ps
module tb_wb_port_arbiter_rr;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*32-1:0] adr, wdat;
  logic [N-1:0]    cyc, stb, we;
  logic [N*3-1:0]  cti;
  logic [N*4-1:0]  sel;
  logic [31:0]     dat_i;
  logic            man_ack, auto_rr, auto_fp, auto_mb;

  logic [N*32-1:0] rr_rdat, fp_rdat, mb_rdat;
  logic [N-1:0]    rr_wback, fp_wback, mb_wback, rr_grant, fp_grant, mb_grant;
  logic            rr_acc, fp_acc, mb_acc, rr_we, fp_we, mb_we;
  logic [31:0]     rr_adr, fp_adr, mb_adr, rr_dat, fp_dat, mb_dat;
  logic [3:0]      rr_sel, fp_sel, mb_sel;
  logic            rr_ack, fp_ack, mb_ack;

  assign rr_ack = auto_rr ? rr_acc : man_ack;
  assign fp_ack = auto_fp ? fp_acc : man_ack;
  assign mb_ack = auto_mb ? mb_acc : man_ack;

  wb_port_arbiter_rr #(.WB_PORTS(N), .ARB_MODE(1), .MAX_BEATS(16)) u_rr (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_cti_i(cti), .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(rr_rdat), .wb_ack_o(rr_wback), .acc_o(rr_acc), .we_o(rr_we),
    .adr_o(rr_adr), .dat_o(rr_dat), .sel_o(rr_sel), .dat_i(dat_i),
    .ack_i(rr_ack), .grant_o(rr_grant));

  wb_port_arbiter_rr #(.WB_PORTS(N), .ARB_MODE(0), .MAX_BEATS(16)) u_fp (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_cti_i(cti), .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(fp_rdat), .wb_ack_o(fp_wback), .acc_o(fp_acc), .we_o(fp_we),
    .adr_o(fp_adr), .dat_o(fp_dat), .sel_o(fp_sel), .dat_i(dat_i),
    .ack_i(fp_ack), .grant_o(fp_grant));

  wb_port_arbiter_rr #(.WB_PORTS(N), .ARB_MODE(1), .MAX_BEATS(4)) u_mb (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_cti_i(cti), .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(mb_rdat), .wb_ack_o(mb_wback), .acc_o(mb_acc), .we_o(mb_we),
    .adr_o(mb_adr), .dat_o(mb_dat), .sel_o(mb_sel), .dat_i(dat_i),
    .ack_i(mb_ack), .grant_o(mb_grant));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic c, input logic [2:0] t);
    cyc[p] = c;
    stb[p] = c;
    cti[p*3 +: 3] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0; cti = '0; sel = '0; adr = '0; wdat = '0;
    dat_i = '0; man_ack = 1'b0; auto_rr = 1'b0; auto_fp = 1'b0; auto_mb = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int oh2i(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 7;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  cyc;
    logic        ack;
    logic [31:0] dat;
    logic        acc;
    logic [2:0]  wback;
    logic [2:0]  grant;
  } vec_t;

  vec_t tv[6];
  int   exp_rr[6] = '{0, 1, 2, 0, 1, 2};
  int   exp_mb[7] = '{0, 0, 0, 0, 1, 0, 0};

  initial begin
    // Port 1 classic read, ack two cycles after acc_o rises
    tv[0] = '{3'b010, 1'b0, 32'h0,        1'b0, 3'b000, 3'b000};
    tv[1] = '{3'b010, 1'b0, 32'h0,        1'b1, 3'b000, 3'b010};
    tv[2] = '{3'b010, 1'b0, 32'h0,        1'b1, 3'b000, 3'b010};
    tv[3] = '{3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 3'b010, 3'b010};
    tv[4] = '{3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 3'b000};
    tv[5] = '{3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 3'b000};

    do_reset();
    adr[63:32] = 32'h1000_0104;
    sel[7:4]   = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc = tv[i].cyc; stb = tv[i].cyc; man_ack = tv[i].ack; dat_i = tv[i].dat;
      @(negedge clk);
      chk($sformatf("single_acc[%0d]", i), 32'(rr_acc), 32'(tv[i].acc));
      chk($sformatf("single_ack[%0d]", i), 32'(rr_wback), 32'(tv[i].wback));
      chk($sformatf("single_grant[%0d]", i), 32'(rr_grant), 32'(tv[i].grant));
      if (tv[i].wback != 3'b000) begin
        chk("single_rdat1", rr_rdat[63:32], tv[i].dat);
        chk("single_adr", rr_adr, 32'h1000_0104);
        chk("single_sel", 32'(rr_sel), 32'hF);
      end
      step();
    end

    // Continuous classic singles from all ports: round-robin vs fixed priority
    begin
      int nr, nf;
      int ord_r[6];
      int ord_f[6];
      nr = 0; nf = 0;
      do_reset();
      auto_rr = 1'b1; auto_fp = 1'b1;
      for (int p = 0; p < N; p++) set_port(p, 1'b1, 3'b000);
      for (int c = 0; c < 40 && (nr < 6 || nf < 6); c++) begin
        @(negedge clk);
        if (rr_wback != 3'b000 && nr < 6) begin ord_r[nr] = oh2i(rr_wback); nr++; end
        if (fp_wback != 3'b000 && nf < 6) begin ord_f[nf] = oh2i(fp_wback); nf++; end
        step();
      end
      chk("rr_ack_count", nr, 6);
      chk("fp_ack_count", nf, 6);
      for (int k = 0; k < 6; k++) begin
        if (k < nr) chk($sformatf("rr_order[%0d]", k), ord_r[k], exp_rr[k]);
        if (k < nf) chk($sformatf("fp_order[%0d]", k), ord_f[k], 0);
      end
    end

    // Port 0 8-beat burst, port 2 arrives mid-burst
    begin
      int n0, n2, first0, last0, first2;
      logic [2:0] g_hist[40];
      logic       a_hist[40];
      n0 = 0; n2 = 0; first0 = -1; last0 = -1; first2 = -1;
      do_reset();
      auto_rr = 1'b1;
      for (int c = 0; c < 40; c++) begin
        set_port(0, n0 < 8, (n0 == 7) ? 3'b111 : 3'b010);
        set_port(2, n0 >= 3 && n2 == 0, 3'b000);
        @(negedge clk);
        g_hist[c] = rr_grant;
        a_hist[c] = rr_acc;
        if (rr_wback[0]) begin
          if (first0 < 0) first0 = c;
          last0 = c;
          n0++;
        end
        if (rr_wback[2] && first2 < 0) begin first2 = c; n2++; end
        step();
      end
      chk("burst_beats", n0, 8);
      chk("burst_span", last0 - first0, 7);
      if (last0 >= 0 && last0 < 37) begin
        chk("burst_release_grant", 32'(g_hist[last0 + 1]), 0);
        chk("burst_release_acc", 32'(a_hist[last0 + 1]), 0);
        chk("burst_idle_grant", 32'(g_hist[last0 + 2]), 0);
        chk("burst_next_grant", 32'(g_hist[last0 + 3]), 32'b100);
        chk("burst_p2_ack_cycle", first2, last0 + 3);
      end else begin
        chk("burst_last_beat_seen", 0, 1);
      end
    end

    // MAX_BEATS=4: long burst on port 0 preempted for waiting port 1
    begin
      int n0, n1, ns;
      int seq[7];
      logic [31:0] adr5;
      n0 = 0; n1 = 0; ns = 0; adr5 = '0;
      do_reset();
      auto_mb = 1'b1;
      for (int c = 0; c < 40 && ns < 7; c++) begin
        set_port(0, 1'b1, 3'b010);
        adr[31:0] = 32'h0000_1000 + 32'(4 * n0);
        set_port(1, n1 == 0, 3'b000);
        @(negedge clk);
        if (mb_wback != 3'b000) begin
          seq[ns] = oh2i(mb_wback);
          ns++;
          if (mb_wback[0]) begin
            if (n0 == 4) adr5 = mb_adr;
            n0++;
          end else if (mb_wback[1]) begin
            n1++;
          end
        end
        step();
      end
      chk("limit_ack_count", ns, 7);
      for (int k = 0; k < 7; k++)
        if (k < ns) chk($sformatf("limit_order[%0d]", k), seq[k], exp_mb[k]);
      chk("limit_resume_adr", adr5, 32'h0000_1010);
    end

    // Port 1 aborts a burst after 2 beats; late ack lands in RELEASE
    do_reset();
    set_port(1, 1'b1, 3'b010);
    we[1] = 1'b1; wdat[63:32] = 32'hCAFE_0001; sel[7:4] = 4'h3;
    @(negedge clk);
    chk("abort_idle_acc", 32'(rr_acc), 0);
    step();
    man_ack = 1'b1;
    @(negedge clk);
    chk("abort_beat1_ack", 32'(rr_wback), 32'b010);
    chk("abort_we", 32'(rr_we), 1);
    chk("abort_wdat", rr_dat, 32'hCAFE_0001);
    chk("abort_sel", 32'(rr_sel), 32'h3);
    step();
    @(negedge clk);
    chk("abort_beat2_ack", 32'(rr_wback), 32'b010);
    step();
    set_port(1, 1'b0, 3'b010);
    man_ack = 1'b0;
    @(negedge clk);
    chk("abort_acc_drop", 32'(rr_acc), 0);
    chk("abort_grant_held", 32'(rr_grant), 32'b010);
    step();
    man_ack = 1'b1;
    @(negedge clk);
    chk("abort_late_ack", 32'(rr_wback), 0);
    chk("abort_release_grant", 32'(rr_grant), 0);
    step();
    man_ack = 1'b0;

    // Reset mid-burst clears grant and the round-robin pointer
    begin
      int n1;
      logic got0;
      n1 = 0; got0 = 1'b0;
      do_reset();
      auto_rr = 1'b1;
      set_port(0, 1'b1, 3'b000);
      for (int c = 0; c < 10 && !got0; c++) begin
        @(negedge clk);
        if (rr_wback[0]) got0 = 1'b1;
        step();
      end
      chk("rst_pre_port0_served", 32'(got0), 1);
      set_port(0, 1'b0, 3'b000);
      set_port(1, 1'b1, 3'b010);
      for (int c = 0; c < 20 && n1 < 3; c++) begin
        @(negedge clk);
        if (rr_wback[1]) n1++;
        step();
      end
      chk("rst_pre_burst_beats", n1, 3);
      rst = 1'b1;
      set_port(0, 1'b1, 3'b000);
      set_port(2, 1'b1, 3'b000);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_acc", 32'(rr_acc), 0);
      chk("rst_grant", 32'(rr_grant), 0);
      chk("rst_ack", 32'(rr_wback), 0);
      step();
      @(negedge clk);
      chk("rst_first_grant", 32'(rr_grant), 32'b001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
